jk_reg_bank: RTL and testbench

Parametrised successor to the single-bit JK flip-flop. It holds a WIDTH-bit bank of JK flip-flops with per-bit J/K control, and adds a clock enable, an asynchronous reset, and three extra modes: up-count, down-count and parallel load. It sits wherever the design currently instantiates several single JK flip-flops side by side or wraps them into ad-hoc counters.

---
 rtl/jk_reg_bank.sv | 71 +++++++
 tb/tb_jk_reg_bank.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flops with clock enable and async reset.
// Extra modes: up-count, down-count and parallel load.
module jk_reg_bank #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] reState,
    output logic             tc,
    output logic             changed
);

    logic [WIDTH-1:0] state_q, state_d;
    logic             changed_q;
    logic             carry;

    // Count modes use the JK toggle rule: a bit toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        state_d = state_q;
        carry   = 1'b1;
        if (en) begin
            unique case (mode)
                2'b00: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        unique case ({J[i], K[i]})
                            2'b00: state_d[i] = state_q[i];
                            2'b10: state_d[i] = 1'b1;
                            2'b01: state_d[i] = 1'b0;
                            default: state_d[i] = ~state_q[i];
                        endcase
                    end
                end
                2'b01: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        state_d[i] = state_q[i] ^ carry;
                        carry      = carry & state_q[i];
                    end
                end
                2'b10: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        state_d[i] = state_q[i] ^ carry;
                        carry      = carry & ~state_q[i];
                    end
                end
                default: state_d = J;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RESET_VAL;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            changed_q <= (state_d != state_q);
        end
    end

    assign state   = state_q;
    assign reState = ~state_q;
    assign changed = changed_q;
    assign tc      = en & (((mode == 2'b01) & (&state_q)) | ((mode == 2'b10) & ~(|state_q)));

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank (WIDTH=4) with an expected-result queue.
module tb_jk_reg_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] J, K;
    logic [3:0] state, reState;
    logic       tc, changed;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       ch;
    } exp_t;

    exp_t sb[$];

    jk_reg_bank #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .J       (J),
        .K       (K),
        .state   (state),
        .reState (reState),
        .tc      (tc),
        .changed (changed)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed running, required finished");
        $fatal(1, "timeout");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle: check tc before the edge, queue expected result, compare after the edge.
    task automatic step(input string tag, input logic [1:0] m, input logic e,
                        input logic [3:0] j, input logic [3:0] k,
                        input logic [3:0] es, input logic ec, input logic etc);
        exp_t x;
        mode = m; en = e; J = j; K = k;
        #1;
        chk1({tag, "_tc"}, tc, etc);
        sb.push_back('{st: es, ch: ec});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk4({tag, "_state"}, state, x.st);
        chk4({tag, "_restate"}, reState, ~x.st);
        chk1({tag, "_changed"}, changed, x.ch);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; J = '0; K = '0;
        #2;
        chk4("por_state", state, 4'b0000);
        chk4("por_restate", reState, 4'b1111);
        chk1("por_changed", changed, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Async reset mid-cycle from 1010
        step("load1010", 2'b11, 1'b1, 4'b1010, 4'b0000, 4'b1010, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk4("arst_state", state, 4'b0000);
        chk4("arst_restate", reState, 4'b1111);
        chk1("arst_changed", changed, 1'b0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // JK truth table
        step("jk_mix", 2'b00, 1'b1, 4'b1100, 4'b1010, 4'b0100, 1'b1, 1'b0);
        step("jk_hold", 2'b00, 1'b1, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0);
        step("jk_tog", 2'b00, 1'b1, 4'b1111, 4'b1111, 4'b1011, 1'b1, 1'b0);

        // Up-count with wrap
        step("ld1101", 2'b11, 1'b1, 4'b1101, 4'b1111, 4'b1101, 1'b1, 1'b0);
        step("up1", 2'b01, 1'b1, 4'b0000, 4'b0000, 4'b1110, 1'b1, 1'b0);
        step("up2", 2'b01, 1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0);
        step("up3", 2'b01, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
        step("up4", 2'b01, 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0);

        // Down-count with wrap
        step("dn1", 2'b10, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
        step("dn2", 2'b10, 1'b1, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b1);
        step("dn3", 2'b10, 1'b1, 4'b0000, 4'b0000, 4'b1110, 1'b1, 1'b0);

        // Load current value reports no change; tc low in load mode
        step("ld_same", 2'b11, 1'b1, 4'b1110, 4'b0000, 4'b1110, 1'b0, 1'b0);

        // Enable hold
        step("ld0101", 2'b11, 1'b1, 4'b0101, 4'b0000, 4'b0101, 1'b1, 1'b0);
        step("hold1", 2'b01, 1'b0, 4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b0);
        step("hold2", 2'b01, 1'b0, 4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b0);
        step("hold3", 2'b01, 1'b0, 4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b0);
        step("reen", 2'b01, 1'b1, 4'b0000, 4'b0000, 4'b0110, 1'b1, 1'b0);

        // Disabled at all-ones in up mode: tc must stay low
        step("ld1111", 2'b11, 1'b1, 4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b0);
        step("dis_tc", 2'b01, 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0);

        // Load then reset mid-operation
        step("ld1001", 2'b11, 1'b1, 4'b1001, 4'b1111, 4'b1001, 1'b1, 1'b0);
        mode = 2'b01;
        #2 rst = 1'b1;
        #1;
        chk4("rst2_state", state, 4'b0000);
        chk1("rst2_changed", changed, 1'b0);
        #1 rst = 1'b0;
        step("post_rst", 2'b01, 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
